// File: rtl/speed_sel_pkg.sv
// Shared types and widths for the button-driven blink speed selector.
// Latency: none (types and constants only).
// Backpressure: none.
package speed_sel_pkg;

  localparam int SPEED_W = 16;

  // Defaults of the debounce and hold windows; the ms counters are sized for
  // the larger of the two so a full hold period fits without wrapping.
  localparam int DEF_DEBOUNCE_MS = 20;
  localparam int DEF_HOLD_MS     = 500;
  localparam int CNT_MAX = (DEF_DEBOUNCE_MS > DEF_HOLD_MS) ? DEF_DEBOUNCE_MS : DEF_HOLD_MS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } deb_state_t;

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes and debounces one raw button, emitting step events with hold-to-repeat.
// Latency: 2 clk sync, then DEBOUNCE_MS tics to the first event; event is a registered 1-clk pulse.
// Backpressure: none; events are fire-and-forget pulses, at most one per tic.
module button_debouncer
  import speed_sel_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLD_MS     = 500,
  parameter int REPEAT_MS   = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic tic,
  input  logic btn,
  output logic evt
);

  localparam logic [CNT_W-1:0] DEB_C  = CNT_W'(DEBOUNCE_MS);
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_MS);
  localparam logic [CNT_W-1:0] REP_C  = CNT_W'(REPEAT_MS);

  logic             sync1;
  logic             sync2;
  deb_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             repeating;

  assign cnt_inc = cnt + 1'b1;

  // Two-flop synchronizer; only the second flop feeds the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Debounce / hold / repeat FSM; counters only move on tic so events are tic-aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      repeating <= 1'b0;
      evt       <= 1'b0;
    end else begin
      evt <= 1'b0;
      case (state)
        IDLE: begin
          if (sync2) begin
            state <= WAIT_PRESS;
            cnt   <= '0;
          end
        end
        WAIT_PRESS: begin
          if (!sync2) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (tic) begin
            if (cnt_inc == DEB_C) begin
              state     <= PRESSED;
              evt       <= 1'b1;
              cnt       <= '0;
              repeating <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        PRESSED: begin
          if (!sync2) begin
            state <= WAIT_RELEASE;
            cnt   <= '0;
          end else if (tic) begin
            // First period is the long hold, then the shorter repeat interval.
            if (cnt_inc == (repeating ? REP_C : HOLD_C)) begin
              evt       <= 1'b1;
              repeating <= 1'b1;
              cnt       <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        WAIT_RELEASE: begin
          if (sync2) begin
            // Release bounce: resume the press silently, restarting repeat timing.
            state     <= PRESSED;
            cnt       <= '0;
            repeating <= 1'b0;
          end else if (tic) begin
            if (cnt_inc == DEB_C) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/speed_selector.sv
// Turns up/down buttons into a saturating 16-bit blink period for the blink controller.
// Latency: speed updates 1 clk after a debounced step event.
// Backpressure: none; the speed word is a level that downstream samples freely.
module speed_selector
  import speed_sel_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLD_MS     = 500,
  parameter int REPEAT_MS   = 100,
  parameter int STEP        = 100,
  parameter int MIN_SPEED   = 0,
  parameter int MAX_SPEED   = 2000,
  parameter int INIT_SPEED  = 500
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tic,
  input  logic               btn_up,
  input  logic               btn_down,
  output logic [SPEED_W-1:0] speed,
  output logic               at_min,
  output logic               at_max
);

  typedef logic [SPEED_W:0] wide_t;

  localparam logic [SPEED_W-1:0] MIN_S  = SPEED_W'(MIN_SPEED);
  localparam logic [SPEED_W-1:0] MAX_S  = SPEED_W'(MAX_SPEED);
  localparam logic [SPEED_W-1:0] INIT_S = SPEED_W'(INIT_SPEED);
  localparam logic [SPEED_W-1:0] STEP_S = SPEED_W'(STEP);
  localparam wide_t              MIN_W  = wide_t'(MIN_SPEED);
  localparam wide_t              MAX_W  = wide_t'(MAX_SPEED);
  localparam wide_t              STEP_W = wide_t'(STEP);

  logic               evt_up;
  logic               evt_down;
  wide_t              up_sum;
  logic [SPEED_W-1:0] up_val;
  logic [SPEED_W-1:0] down_val;

  button_debouncer #(
    .DEBOUNCE_MS(DEBOUNCE_MS),
    .HOLD_MS    (HOLD_MS),
    .REPEAT_MS  (REPEAT_MS)
  ) u_deb_up (
    .clk(clk),
    .rst(rst),
    .tic(tic),
    .btn(btn_up),
    .evt(evt_up)
  );

  button_debouncer #(
    .DEBOUNCE_MS(DEBOUNCE_MS),
    .HOLD_MS    (HOLD_MS),
    .REPEAT_MS  (REPEAT_MS)
  ) u_deb_down (
    .clk(clk),
    .rst(rst),
    .tic(tic),
    .btn(btn_down),
    .evt(evt_down)
  );

  // Saturating step arithmetic carried one bit wider so it can never wrap.
  assign up_sum   = {1'b0, speed} + STEP_W;
  assign up_val   = (up_sum > MAX_W) ? MAX_S : up_sum[SPEED_W-1:0];
  assign down_val = ({1'b0, speed} < (MIN_W + STEP_W)) ? MIN_S : (speed - STEP_S);

  // Speed register; simultaneous up and down events cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      speed <= INIT_S;
    end else if (evt_up && !evt_down) begin
      speed <= up_val;
    end else if (evt_down && !evt_up) begin
      speed <= down_val;
    end
  end

  assign at_min = (speed == MIN_S);
  assign at_max = (speed == MAX_S);

endmodule
